// File: rtl/io_out_pkg.sv
// io_out_pkg
// Shared definitions for the core output-port stage: width helpers for the
// port address and FIFO pointers, the FIFO entry layout, and the FIFO depth
// sanity check.
// No ports (package).

package io_out_pkg;

  // Width of an output port address; never narrower than one bit.
  function automatic int addr_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // Width of a FIFO read/write pointer; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Pointers wrap by natural overflow, so the depth must be a power of two.
  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  localparam int DEF_NUBITS = 32;
  localparam int DEF_NUIOOU = 8;
  localparam int DEF_FDEPTH = 4;

  localparam bit DEF_FDEPTH_OK = is_pow2(DEF_FDEPTH);

  // FIFO entry layout for the default core configuration: address on top,
  // data below.
  typedef struct packed {
    logic [addr_width(DEF_NUIOOU)-1:0] addr;
    logic [DEF_NUBITS-1:0]             data;
  } io_entry_t;

endpackage

// File: rtl/io_fifo_mem.sv
// io_fifo_mem
// Storage array for the output FIFO: one synchronous write port, one
// asynchronous read port, cleared by reset so an empty FIFO reads zero.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   wr_en     write strobe, wr_ptr selects the entry, wr_data is stored
//   rd_ptr    read address, rd_data is the selected entry (combinational)

module io_fifo_mem
  import io_out_pkg::*;
#(
  parameter int W     = 35,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_ptr,
  input  logic [W-1:0]  wr_data,
  input  logic [PW-1:0] rd_ptr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Entries are cleared on reset so the head reads zero until written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // First-word-fall-through: the head entry is always presented.
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/io_out_buffer.sv
// io_out_buffer
// Output-port stage behind the processor core. Every core output write is
// captured into a small FIFO and drained to peripherals over valid/ready.
// The core cannot stall, so a write arriving while the FIFO is full (and
// nothing leaves that cycle) is dropped and a sticky overflow flag is set.
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   out_en, addr_out, data_out   core output-write strobe, address, data
//   port_valid/addr/data         FIFO head presented to peripherals
//   port_ready                   peripheral accepts the head entry
//   full, level                  FIFO occupancy flags
//   overflow, clr_ovf            sticky drop flag and its synchronous clear
//   hold_data                    last value written per port (optional)
// Optional feature: define IO_OUT_HOLD_EN to add per-port holding registers
// and the hold_data output.

module io_out_buffer
  import io_out_pkg::*;
#(
  parameter  int NUBITS = 32,
  parameter  int NUIOOU = 8,
  parameter  int FDEPTH = 4,
  localparam int AW     = addr_width(NUIOOU),
  localparam int PW     = ptr_width(FDEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_en,
  input  logic [AW-1:0]     addr_out,
  input  logic [NUBITS-1:0] data_out,
  output logic              port_valid,
  output logic [AW-1:0]     port_addr,
  output logic [NUBITS-1:0] port_data,
  input  logic              port_ready,
  output logic              full,
  output logic [PW:0]       level,
  output logic              overflow,
  input  logic              clr_ovf
`ifdef IO_OUT_HOLD_EN
  ,
  output logic [NUIOOU*NUBITS-1:0] hold_data
`endif
);

  localparam int LW = PW + 1;
  localparam logic [PW:0] LEVEL_MAX = LW'(FDEPTH);

  if (!is_pow2(FDEPTH)) begin : g_bad_depth
    $error("io_out_buffer: FDEPTH must be a power of two and at least 2");
  end

  // Same layout as io_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [NUBITS-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;
  entry_t        wr_entry;
  entry_t        rd_entry;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a
  // write when the peripheral is taking the head.
  always_comb begin
    pop      = port_valid && port_ready;
    push     = out_en && (!full || pop);
    drop     = out_en && !push;
    wr_entry = '{addr: addr_out, data: data_out};
  end

  io_fifo_mem #(
    .W     (EW),
    .DEPTH (FDEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_entry),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_entry)
  );

  // Pointers, occupancy and the sticky drop flag. A drop in the same cycle
  // as a clear leaves the flag set so the event is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Head presentation and flags all derive from registered state.
  always_comb begin
    port_valid = (level != '0);
    full       = (level == LEVEL_MAX);
    port_addr  = rd_entry.addr;
    port_data  = rd_entry.data;
  end

`ifdef IO_OUT_HOLD_EN
  logic [NUBITS-1:0] hold [NUIOOU];

  // Only accepted writes update the holding registers; dropped writes never
  // reach a peripheral and so must not change its static level either.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUIOOU; i++) begin
        hold[i] <= '0;
      end
    end else if (push) begin
      hold[addr_out] <= data_out;
    end
  end

  for (genvar g = 0; g < NUIOOU; g++) begin : g_hold_out
    assign hold_data[g*NUBITS +: NUBITS] = hold[g];
  end
`endif

endmodule

// File: tb/tb_io_out_buffer.sv
// tb_io_out_buffer
// Self-checking bench for io_out_buffer. A queue-based reference model
// tracks the expected FIFO contents, overflow flag and (optionally) the
// per-port holding values; directed sequences are followed by random
// traffic. Define IO_OUT_HOLD_EN to also exercise hold_data.

module tb_io_out_buffer;

  localparam int NUBITS = 32;
  localparam int NUIOOU = 8;
  localparam int FDEPTH = 4;
  localparam int AW     = 3;
  localparam int PW     = 2;

  typedef struct packed {
    logic [AW-1:0]     a;
    logic [NUBITS-1:0] d;
  } ent_t;

  logic              clk;
  logic              rst;
  logic              out_en;
  logic [AW-1:0]     addr_out;
  logic [NUBITS-1:0] data_out;
  logic              port_valid;
  logic [AW-1:0]     port_addr;
  logic [NUBITS-1:0] port_data;
  logic              port_ready;
  logic              full;
  logic [PW:0]       level;
  logic              overflow;
  logic              clr_ovf;
`ifdef IO_OUT_HOLD_EN
  logic [NUIOOU*NUBITS-1:0] hold_data;
`endif

  int checks = 0;
  int passes = 0;

  ent_t              mq[$];
  bit                m_ovf;
  logic [NUBITS-1:0] hold_m [NUIOOU];

  io_out_buffer #(
    .NUBITS (NUBITS),
    .NUIOOU (NUIOOU),
    .FDEPTH (FDEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .out_en     (out_en),
    .addr_out   (addr_out),
    .data_out   (data_out),
    .port_valid (port_valid),
    .port_addr  (port_addr),
    .port_data  (port_data),
    .port_ready (port_ready),
    .full       (full),
    .level      (level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
`ifdef IO_OUT_HOLD_EN
    ,
    .hold_data  (hold_data)
`endif
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < NUIOOU; i++) begin
      hold_m[i] = '0;
    end
  endtask

  // One clock edge of the reference: leave first, then enter, with a
  // write refused only when there is no room even after the departure.
  task automatic modelEdge(input bit en, input logic [AW-1:0] a,
                           input logic [NUBITS-1:0] d, input bit rdy,
                           input bit clr);
    bit leaving;
    bit accepted;
    leaving  = (mq.size() > 0) && rdy;
    if (leaving) begin
      void'(mq.pop_front());
    end
    accepted = en && (mq.size() < FDEPTH);
    if (accepted) begin
      mq.push_back('{a: a, d: d});
      hold_m[a] = d;
    end
    if (en && !accepted) begin
      m_ovf = 1'b1;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
  endtask

  task automatic checkModel();
    checkOutput("valid", port_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      checkOutput("head_addr", port_addr, mq[0].a);
      checkOutput("head_data", port_data, mq[0].d);
    end
    checkOutput("level", level, mq.size());
    checkOutput("full", full, mq.size() == FDEPTH);
    checkOutput("overflow", overflow, m_ovf);
`ifdef IO_OUT_HOLD_EN
    for (int i = 0; i < NUIOOU; i++) begin
      checkOutput("hold", hold_data[i*NUBITS +: NUBITS], hold_m[i]);
    end
`endif
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare just
  // after it.
  task automatic applyStimulus(input bit en, input logic [AW-1:0] a,
                               input logic [NUBITS-1:0] d, input bit rdy,
                               input bit clr);
    out_en     = en;
    addr_out   = a;
    data_out   = d;
    port_ready = rdy;
    clr_ovf    = clr;
    @(posedge clk);
    modelEdge(en, a, d, rdy, clr);
    #1;
    checkModel();
  endtask

  initial begin
    rst        = 1'b1;
    out_en     = 1'b0;
    addr_out   = '0;
    data_out   = '0;
    port_ready = 1'b0;
    clr_ovf    = 1'b0;
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_level", level, 0);
    checkOutput("rst_valid", port_valid, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_data", port_data, 0);
    rst = 1'b0;

    $display("[TB] single write");
    applyStimulus(1, 3'd5, 32'h12345678, 1, 0);
    checkOutput("single_valid", port_valid, 1);
    checkOutput("single_addr", port_addr, 5);
    checkOutput("single_data", port_data, 32'h12345678);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("single_level", level, 0);

    $display("[TB] fill and overflow");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 3'(i), 32'(i), 0, 0);
    end
    checkOutput("fill_full", full, 1);
    checkOutput("fill_level", level, 4);
    checkOutput("fill_overflow", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain_order", port_data, 32'(i));
      applyStimulus(0, 0, 0, 1, 0);
    end
    checkOutput("drain_empty", port_valid, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("clr_ovf", overflow, 0);

    $display("[TB] full with simultaneous pop and push");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 3'(i), 32'(11 + i), 0, 0);
    end
    applyStimulus(1, 3'd6, 32'd9, 1, 0);
    checkOutput("pp_level", level, 4);
    checkOutput("pp_overflow", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("pp_order", port_data, (i < 3) ? 32'(12 + i) : 32'd9);
      applyStimulus(0, 0, 0, 1, 0);
    end

    $display("[TB] backpressure");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i % 2 == 0, 3'(i / 2), 32'(100 + i / 2), i % 2 == 1, 0);
    end
    repeat (10) applyStimulus(0, 0, 0, 1, 0);
    checkOutput("bp_drained", level, 0);

    $display("[TB] reset mid-burst");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 3'(i), 32'(21 + i), 0, 0);
    end
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("pre_rst_level", level, 3);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_level", level, 0);
    checkOutput("arst_valid", port_valid, 0);
    checkOutput("arst_overflow", overflow, 0);
    checkOutput("arst_data", port_data, 0);
    checkOutput("arst_full", full, 0);
    modelReset();
    port_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkModel();

`ifdef IO_OUT_HOLD_EN
    $display("[TB] holding registers");
    applyStimulus(1, 3'd2, 32'hAA, 1, 0);
    applyStimulus(1, 3'd2, 32'hBB, 1, 0);
    applyStimulus(1, 3'd7, 32'hCC, 1, 0);
    for (int i = 0; i < NUIOOU; i++) begin
      checkOutput("hold_dir", hold_data[i*NUBITS +: NUBITS],
                  (i == 2) ? 32'hBB : (i == 7) ? 32'hCC : 32'h0);
    end
    repeat (3) applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 3'd3, 32'h33, 0, 0);
    end
    applyStimulus(1, 3'd3, 32'h99, 0, 0);
    checkOutput("hold_drop", hold_data[3*NUBITS +: NUBITS], 32'h33);
    repeat (5) applyStimulus(0, 0, 0, 1, 1);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
                    $urandom, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 15) == 0);
    end
    repeat (6) applyStimulus(0, 0, 0, 1, 1);
    checkOutput("end_level", level, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
